// File: rtl/keypad_if.sv
// keypad_if -- bundles the keypad matrix lines and the key hand-off signals.
//   row       : 4-bit keypad row lines, active-low, asynchronous to clk
//   col       : 4-bit column strobes, active-low, exactly one low
//   key_code  : accepted key, col_index*4 + row_index
//   key_valid : key_code holds an unconsumed key
//   key_ack   : consumer acknowledge for key_valid
//   overrun   : sticky flag, a key was dropped while key_valid was pending
// Modport master is the scanner side; slave is the keypad/consumer side.
interface keypad_if;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ack;
  logic       overrun;

  modport master (
    input  row, key_ack,
    output col, key_code, key_valid, overrun
  );

  modport slave (
    output row, key_ack,
    input  col, key_code, key_valid, overrun
  );
endinterface

// File: rtl/keypad_scan.sv
// keypad_scan -- 4x4 matrix keypad scanner with per-scan debounce and a
// single-entry key hand-off register.
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset
//   kp   : keypad_if.master (row, col, key_code, key_valid, key_ack, overrun)
// Parameters: SCAN_BITS (column period 2^SCAN_BITS cycles), DEBOUNCE_SCANS
// (1..15 full scans to accept press/release), REPEAT_SCANS (1..255).
// Optional feature macro: KEYPAD_AUTOREPEAT_EN -- a held key re-emits every
// REPEAT_SCANS full scans; when undefined no repeat counter is built.
module keypad_scan #(
  parameter int SCAN_BITS      = 17,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int REPEAT_SCANS   = 16
) (
  input  logic     clk,
  input  logic     rst,
  keypad_if.master kp
);

  if (DEBOUNCE_SCANS < 1 || DEBOUNCE_SCANS > 15) begin : g_bad_deb
    $error("DEBOUNCE_SCANS out of range 1..15");
  end
  if (REPEAT_SCANS < 1 || REPEAT_SCANS > 255) begin : g_bad_rpt
    $error("REPEAT_SCANS out of range 1..255");
  end

  typedef enum logic [1:0] {S_IDLE, S_DEBOUNCE, S_PRESSED, S_RELEASE} state_t;

  localparam logic [SCAN_BITS-1:0] DIV_ONE = 1;
  localparam logic [3:0]           DEB_N   = 4'(DEBOUNCE_SCANS);

  logic [3:0]           row_meta_q, row_sync_q;
  logic [SCAN_BITS-1:0] div_q;
  logic [1:0]           col_idx_q;
  logic [1:0]           acc_lows_q;
  logic [3:0]           acc_code_q;
  state_t               state_q, state_d;
  logic [3:0]           cand_q, cand_d;
  logic [3:0]           dcnt_q, dcnt_d;
  logic [3:0]           key_code_q;
  logic                 key_valid_q, overrun_q;

  logic                 tick, scan_done, emit, restart, ack_ok;
  logic [3:0]           row_low, scan_code, dcnt_inc;
  logic [2:0]           pop, lows_sum;
  logic [1:0]           col_lows, row_hit, base_lows, scan_lows;
  logic [3:0]           col_w;

  assign tick      = &div_q;
  assign scan_done = tick && (col_idx_q == 2'd3);
  assign row_low   = ~row_sync_q;
  assign dcnt_inc  = dcnt_q + 4'd1;

  // Low rows in the current column, saturated at 2 (only 0/1/many matters).
  always_comb begin
    pop      = 3'(row_low[0]) + 3'(row_low[1]) + 3'(row_low[2]) + 3'(row_low[3]);
    col_lows = (pop >= 3'd2) ? 2'd2 : pop[1:0];
    row_hit  = 2'd0;
    if (row_low[1]) row_hit = 2'd1;
    if (row_low[2]) row_hit = 2'd2;
    if (row_low[3]) row_hit = 2'd3;
  end

  // Column 0 starts a fresh scan; later columns add to the running tally.
  always_comb begin
    base_lows = (col_idx_q == 2'd0) ? 2'd0 : acc_lows_q;
    lows_sum  = {1'b0, base_lows} + {1'b0, col_lows};
    scan_lows = (lows_sum >= 3'd2) ? 2'd2 : lows_sum[1:0];
    scan_code = (col_lows == 2'd1) ? {col_idx_q, row_hit} : acc_code_q;
  end

  always_comb begin
    case (col_idx_q)
      2'd0:    col_w = 4'b1110;
      2'd1:    col_w = 4'b1101;
      2'd2:    col_w = 4'b1011;
      default: col_w = 4'b0111;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_meta_q <= 4'hF;
      row_sync_q <= 4'hF;
      div_q      <= '0;
      col_idx_q  <= 2'd0;
      acc_lows_q <= 2'd0;
      acc_code_q <= 4'd0;
    end else begin
      row_meta_q <= kp.row;
      row_sync_q <= row_meta_q;
      div_q      <= div_q + DIV_ONE;
      if (tick) begin
        col_idx_q  <= col_idx_q + 2'd1;
        acc_lows_q <= scan_lows;
        acc_code_q <= scan_code;
      end
    end
  end

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam logic [7:0] RPT_N = 8'(REPEAT_SCANS);
  logic [7:0] rpt_q, rpt_d;
`endif

  // Debounce FSM, evaluated only on the tick that closes a full scan.
  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    dcnt_d  = dcnt_q;
    emit    = 1'b0;
    restart = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
    rpt_d   = rpt_q;
`endif
    if (scan_done) begin
      case (state_q)
        S_IDLE: begin
          if (scan_lows == 2'd1) restart = 1'b1;
        end
        S_DEBOUNCE: begin
          if (scan_lows != 2'd1) begin
            state_d = S_IDLE;
          end else if (scan_code != cand_q) begin
            restart = 1'b1;
          end else begin
            dcnt_d = dcnt_inc;
            if (dcnt_inc >= DEB_N) begin
              state_d = S_PRESSED;
              emit    = 1'b1;
            end
          end
        end
        S_PRESSED: begin
          if (scan_lows == 2'd0) begin
            dcnt_d  = 4'd1;
            state_d = (DEB_N <= 4'd1) ? S_IDLE : S_RELEASE;
          end else if (scan_lows == 2'd1 && scan_code != cand_q) begin
            restart = 1'b1;
          end
        end
        default: begin
          if (scan_lows == 2'd0) begin
            dcnt_d = dcnt_inc;
            if (dcnt_inc >= DEB_N) state_d = S_IDLE;
          end else if (scan_lows == 2'd2) begin
            state_d = S_IDLE;
          end else if (scan_code == cand_q) begin
            state_d = S_PRESSED;
          end else begin
            restart = 1'b1;
          end
        end
      endcase
      // A fresh candidate counts as its first debounce scan; with a one-scan
      // debounce that already accepts it.
      if (restart) begin
        cand_d = scan_code;
        dcnt_d = 4'd1;
        if (DEB_N <= 4'd1) begin
          state_d = S_PRESSED;
          emit    = 1'b1;
        end else begin
          state_d = S_DEBOUNCE;
        end
      end
`ifdef KEYPAD_AUTOREPEAT_EN
      if (state_q == S_PRESSED && state_d == S_PRESSED) begin
        if (rpt_q + 8'd1 >= RPT_N) begin
          emit  = 1'b1;
          rpt_d = 8'd0;
        end else begin
          rpt_d = rpt_q + 8'd1;
        end
      end else begin
        rpt_d = 8'd0;
      end
`endif
    end
  end

  assign ack_ok = key_valid_q && kp.key_ack;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cand_q      <= 4'd0;
      dcnt_q      <= 4'd0;
      key_code_q  <= 4'd0;
      key_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
      rpt_q       <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      dcnt_q  <= dcnt_d;
`ifdef KEYPAD_AUTOREPEAT_EN
      rpt_q   <= rpt_d;
`endif
      // An ack in the same cycle frees the slot for the new key.
      if (emit) begin
        if (!key_valid_q || ack_ok) begin
          key_code_q  <= scan_code;
          key_valid_q <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (ack_ok) begin
        key_valid_q <= 1'b0;
      end
    end
  end

  assign kp.col       = col_w;
  assign kp.key_code  = key_code_q;
  assign kp.key_valid = key_valid_q;
  assign kp.overrun   = overrun_q;

endmodule
